// File: rtl/cache_write_buffer_pkg.sv
// Shared LC-3b line types for the write buffer slice.
// The line tag is the address with the 16-byte offset stripped.
package cache_write_buffer_pkg;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef logic [11:0]  line_tag_t;

  localparam int unsigned OFFSET_BITS = 4;

  function automatic lc3b_word line_address(input line_tag_t tag);
    return {tag, {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_write_buffer_if.sv
// Cache-side and memory-side line bus of the write buffer.
// slave is the buffer's view; master is the view of the cache plus memory around it.
interface cache_write_buffer_if;
  import cache_write_buffer_pkg::*;

  logic          cache_read;
  logic          cache_write;
  lc3b_word      cache_address;
  lc3b_cacheline cache_wdata;
  logic          cache_resp;
  lc3b_cacheline cache_rdata;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_cacheline pmem_wdata;
  logic          pmem_resp;
  lc3b_cacheline pmem_rdata;

  modport slave (
    input  cache_read, cache_write, cache_address, cache_wdata, pmem_resp, pmem_rdata,
    output cache_resp, cache_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output cache_read, cache_write, cache_address, cache_wdata, pmem_resp, pmem_rdata,
    input  cache_resp, cache_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_write_buffer_wb_entry.sv
// Single buffered line: valid flag, tag and data, with a tag-match output.
// Only valid needs a reset; tag and data are meaningless while valid is low.
module wb_entry
  import cache_write_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          clear,
  input  line_tag_t     load_tag,
  input  lc3b_cacheline load_data,
  input  line_tag_t     cmp_tag,
  output logic          valid,
  output line_tag_t     tag,
  output lc3b_cacheline data,
  output logic          hit
);
  logic          valid_reg;
  line_tag_t     tag_reg;
  lc3b_cacheline data_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      tag_reg  <= load_tag;
      data_reg <= load_data;
    end
  end

  assign valid = valid_reg;
  assign tag   = tag_reg;
  assign data  = data_reg;
  assign hit   = valid_reg && (cmp_tag == tag_reg);
endmodule

// File: rtl/cache_write_buffer.sv
// One-entry write-back buffer between the cache and physical memory.
// Evictions are absorbed in one cycle, drained in the background, and forwarded to reads.
module cache_write_buffer
  import cache_write_buffer_pkg::*;
(
  input logic                 clk,
  input logic                 reset_n,
  cache_write_buffer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;

  state_t        state_reg;
  logic          entry_valid;
  logic          entry_hit;
  logic          entry_load;
  logic          entry_clear;
  line_tag_t     entry_tag;
  lc3b_cacheline entry_data;
  line_tag_t     req_tag;

  logic          cache_resp_reg;
  lc3b_cacheline cache_rdata_reg;
  logic          pmem_read_reg;
  logic          pmem_write_reg;
  lc3b_word      pmem_address_reg;
  lc3b_cacheline pmem_wdata_reg;

  assign req_tag     = bus.cache_address[15:4];
  assign entry_load  = (state_reg == IDLE) && bus.cache_write && !entry_valid;
  assign entry_clear = (state_reg == DRAIN) && bus.pmem_resp;

  wb_entry u_entry (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (entry_load),
    .clear     (entry_clear),
    .load_tag  (req_tag),
    .load_data (bus.cache_wdata),
    .cmp_tag   (req_tag),
    .valid     (entry_valid),
    .tag       (entry_tag),
    .data      (entry_data),
    .hit       (entry_hit)
  );

  // All memory-side outputs are registered on state entry, so they hold steady for a whole request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      cache_resp_reg   <= 1'b0;
      cache_rdata_reg  <= '0;
      pmem_read_reg    <= 1'b0;
      pmem_write_reg   <= 1'b0;
      pmem_address_reg <= '0;
      pmem_wdata_reg   <= '0;
    end else begin
      cache_resp_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.cache_write) begin
            if (!entry_valid) begin
              cache_resp_reg <= 1'b1;
              state_reg      <= RESP;
            end else begin
              pmem_write_reg   <= 1'b1;
              pmem_address_reg <= line_address(entry_tag);
              pmem_wdata_reg   <= entry_data;
              state_reg        <= DRAIN;
            end
          end else if (bus.cache_read && entry_hit) begin
            cache_rdata_reg <= entry_data;
            cache_resp_reg  <= 1'b1;
            state_reg       <= RESP;
          end else if (bus.cache_read) begin
            // Refill goes ahead of any pending drain to keep miss latency low.
            pmem_read_reg    <= 1'b1;
            pmem_address_reg <= line_address(req_tag);
            state_reg        <= READ;
          end else if (entry_valid) begin
            pmem_write_reg   <= 1'b1;
            pmem_address_reg <= line_address(entry_tag);
            pmem_wdata_reg   <= entry_data;
            state_reg        <= DRAIN;
          end
        end
        READ: begin
          if (bus.pmem_resp) begin
            pmem_read_reg   <= 1'b0;
            cache_rdata_reg <= bus.pmem_rdata;
            cache_resp_reg  <= 1'b1;
            state_reg       <= RESP;
          end
        end
        DRAIN: begin
          if (bus.pmem_resp) begin
            pmem_write_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        RESP: begin
          // The cache may still hold its request this cycle, so nothing is sampled here.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cache_resp   = cache_resp_reg;
  assign bus.cache_rdata  = cache_rdata_reg;
  assign bus.pmem_read    = pmem_read_reg;
  assign bus.pmem_write   = pmem_write_reg;
  assign bus.pmem_address = pmem_address_reg;
  assign bus.pmem_wdata   = pmem_wdata_reg;
endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed and random checks of the write buffer against a coherent-memory model.
// The bench plays both the cache and a variable-latency physical memory.
module tb_cache_write_buffer;
  import cache_write_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_write_buffer_if bus();
  cache_write_buffer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    bit           is_write;
    logic [15:0]  addr;
    logic [127:0] data;
  } ev_t;

  int errors = 0;
  int checks = 0;
  int mem_lat = 2;
  int rd_cycles = 0;
  int resp_pulses = 0;
  logic [127:0] mem    [logic [11:0]];
  logic [127:0] golden [logic [11:0]];
  ev_t log_q[$];

  logic         prev_act = 1'b0;
  logic         prev_wr = 1'b0;
  logic [15:0]  prev_addr = '0;
  logic [127:0] prev_wdata = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [11:0] t);
    return {8{{t, 4'h0} ^ 16'hC3C3}};
  endfunction

  function automatic logic [127:0] mem_line(input logic [11:0] t);
    return mem.exists(t) ? mem[t] : init_line(t);
  endfunction

  function automatic logic [127:0] golden_line(input logic [11:0] t);
    return golden.exists(t) ? golden[t] : init_line(t);
  endfunction

  function automatic ev_t get_ev(input int i);
    ev_t e;
    e.is_write = 1'b0;
    e.addr     = 16'hFFFF;
    e.data     = '0;
    if (i < log_q.size()) e = log_q[i];
    return e;
  endfunction

  // Physical memory: answers each request after mem_lat cycles of it being visible.
  initial begin : memory
    int cnt;
    ev_t e;
    cnt = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (!reset_n) begin
        cnt = 0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          bus.pmem_resp = 1'b1;
          e.is_write = bus.pmem_write;
          e.addr     = bus.pmem_address;
          e.data     = bus.pmem_wdata;
          if (bus.pmem_write) mem[bus.pmem_address[15:4]] = bus.pmem_wdata;
          else bus.pmem_rdata = mem_line(bus.pmem_address[15:4]);
          log_q.push_back(e);
        end
      end
    end
  end

  // Bus rules: exclusive read/write, aligned addresses, outputs stable during a request.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.cache_resp) resp_pulses++;
      if (bus.pmem_read) rd_cycles++;
      if (bus.pmem_read || bus.pmem_write) begin
        check("pmem_exclusive", {127'b0, bus.pmem_read && bus.pmem_write}, '0);
        check("pmem_align", {124'b0, bus.pmem_address[3:0]}, '0);
        if (prev_act) begin
          check("pmem_addr_stable", {112'b0, bus.pmem_address}, {112'b0, prev_addr});
          if (prev_wr) check("pmem_wdata_stable", bus.pmem_wdata, prev_wdata);
        end
      end
      prev_act   = bus.pmem_read || bus.pmem_write;
      prev_wr    = bus.pmem_write;
      prev_addr  = bus.pmem_address;
      prev_wdata = bus.pmem_wdata;
    end
  end

  task automatic cache_op(input bit wr, input logic [15:0] addr, input logic [127:0] wd,
                          output int lat, output logic [127:0] rd);
    @(negedge clk);
    bus.cache_write   = wr;
    bus.cache_read    = !wr;
    bus.cache_address = addr;
    bus.cache_wdata   = wd;
    lat = 0;
    rd  = 'x;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.cache_resp) begin
        lat = n;
        rd  = bus.cache_rdata;
        break;
      end
    end
    check("cache_resp_seen", {127'b0, lat > 0}, 128'd1);
    if (lat > 0) begin
      @(posedge clk);
      #1;
    end
    bus.cache_read  = 1'b0;
    bus.cache_write = 1'b0;
    if (wr) golden[addr[15:4]] = wd;
    $display("op %s addr=%h lat=%0d rdata=%h", wr ? "WR" : "RD", addr, lat, rd);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_cache_resp"}, {127'b0, bus.cache_resp}, '0);
    check({pfx, "_cache_rdata"}, bus.cache_rdata, '0);
    check({pfx, "_pmem_read"}, {127'b0, bus.pmem_read}, '0);
    check({pfx, "_pmem_write"}, {127'b0, bus.pmem_write}, '0);
    check({pfx, "_pmem_address"}, {112'b0, bus.pmem_address}, '0);
    check({pfx, "_pmem_wdata"}, bus.pmem_wdata, '0);
  endtask

  initial begin : stimulus
    int lat;
    int seen;
    int hi;
    int rc0;
    int rp0;
    logic [127:0] rd;
    logic [127:0] exp;
    ev_t e;
    logic [11:0] t;
    logic [15:0] a;
    logic [127:0] d;
    bit wr;

    bus.cache_read    = 1'b0;
    bus.cache_write   = 1'b0;
    bus.cache_address = '0;
    bus.cache_wdata   = '0;

    // Reset state
    idle(3);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Writeback then refill: the refill reaches memory before the drain
    mem_lat = 3;
    log_q.delete();
    cache_op(1'b1, 16'h1230, {16{8'hA5}}, lat, rd);
    check("wb_empty_lat", lat, 1);
    cache_op(1'b0, 16'h4560, '0, lat, rd);
    check("refill_lat", lat, 4);
    check("refill_data", rd, golden_line(12'h456));
    check("refill_first_n", log_q.size(), 1);
    e = get_ev(0);
    check("refill_first_is_read", {127'b0, e.is_write}, '0);
    check("refill_first_addr", {112'b0, e.addr}, {112'b0, 16'h4560});
    idle(12);
    e = get_ev(1);
    check("drain_is_write", {127'b0, e.is_write}, 128'd1);
    check("drain_addr", {112'b0, e.addr}, {112'b0, 16'h1230});
    check("drain_data", e.data, {16{8'hA5}});

    // Forwarding from the buffer
    mem_lat = 2;
    log_q.delete();
    rc0 = rd_cycles;
    cache_op(1'b1, 16'h2000, {8{16'h1111}}, lat, rd);
    cache_op(1'b0, 16'h2006, '0, lat, rd);
    check("fwd_lat", lat, 1);
    check("fwd_data", rd, {8{16'h1111}});
    check("fwd_no_pmem_read", rd_cycles - rc0, 0);
    idle(12);
    e = get_ev(0);
    check("fwd_drain_addr", {112'b0, e.addr}, {112'b0, 16'h2000});

    // Write into a full buffer waits for the drain
    log_q.delete();
    cache_op(1'b1, 16'h3000, {4{32'hDEAD_0003}}, lat, rd);
    cache_op(1'b1, 16'h5000, {4{32'hBEEF_0005}}, lat, rd);
    check("full_lat", lat, 4);
    check("full_drain_done_n", log_q.size(), 1);
    e = get_ev(0);
    check("full_drain_addr", {112'b0, e.addr}, {112'b0, 16'h3000});
    check("full_drain_data", e.data, {4{32'hDEAD_0003}});
    cache_op(1'b0, 16'h5008, '0, lat, rd);
    check("full_holds_lat", lat, 1);
    check("full_holds_data", rd, {4{32'hBEEF_0005}});
    idle(12);
    e = get_ev(1);
    check("full_second_drain", {112'b0, e.addr}, {112'b0, 16'h5000});

    // Held request through RESP: one memory read, one response
    log_q.delete();
    rp0 = resp_pulses;
    cache_op(1'b0, 16'h7770, '0, lat, rd);
    idle(4);
    check("held_lat", lat, 3);
    check("held_data", rd, golden_line(12'h777));
    check("held_reads", log_q.size(), 1);
    check("held_resps", resp_pulses - rp0, 1);

    // Idle drain: write held for the full memory latency, then buffer empty
    mem_lat = 4;
    log_q.delete();
    cache_op(1'b1, 16'h6000, {2{64'h0123_4567_89AB_CDEF}}, lat, rd);
    seen = 0;
    for (int n = 0; n < 4 && seen == 0; n++) begin
      @(negedge clk);
      if (bus.pmem_write) seen = 1;
    end
    check("idle_drain_started", seen, 1);
    check("idle_drain_addr", {112'b0, bus.pmem_address}, {112'b0, 16'h6000});
    check("idle_drain_wdata", bus.pmem_wdata, {2{64'h0123_4567_89AB_CDEF}});
    hi = seen;
    for (int n = 0; n < 20 && seen == 1; n++) begin
      @(negedge clk);
      if (bus.pmem_write) hi++;
      else seen = 0;
    end
    check("idle_drain_held", hi, 4);
    rc0 = rd_cycles;
    cache_op(1'b0, 16'h6004, '0, lat, rd);
    check("after_drain_miss_lat", lat, 5);
    check("after_drain_data", rd, {2{64'h0123_4567_89AB_CDEF}});
    check("after_drain_reads", rd_cycles - rc0, 4);

    // Reset in the middle of a drain loses the line
    mem_lat = 20;
    cache_op(1'b1, 16'h0040, {4{32'h0BAD_F00D}}, lat, rd);
    seen = 0;
    for (int n = 0; n < 4 && seen == 0; n++) begin
      @(negedge clk);
      if (bus.pmem_write) seen = 1;
    end
    check("mid_drain_started", seen, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    golden = mem;
    idle(2);
    reset_n = 1'b1;
    mem_lat = 2;
    rc0 = rd_cycles;
    cache_op(1'b0, 16'h0040, '0, lat, rd);
    check("post_reset_lat", lat, 3);
    check("post_reset_data", rd, golden_line(12'h004));
    check("post_reset_reads", rd_cycles - rc0, 2);

    // Random traffic over a few aliasing lines
    for (int i = 0; i < 40; i++) begin
      t  = 12'h100 + 12'($urandom_range(0, 3));
      a  = {t, 4'($urandom_range(0, 15))};
      wr = 1'($urandom_range(0, 1));
      d  = {$urandom, $urandom, $urandom, $urandom};
      mem_lat = $urandom_range(1, 4);
      exp = golden_line(t);
      cache_op(wr, a, d, lat, rd);
      if (!wr) check("rand_rdata", rd, exp);
      idle($urandom_range(0, 2));
    end
    idle(20);
    foreach (golden[k]) check("final_mem", mem_line(k), golden[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
